// File: rtl/sap_ram_loader.sv
// sap_ram_loader: sits in front of the 16x4 SRAM pair (8-bit words).
// Program mode turns single write requests into setup / write pulse / hold /
// read-back verify cycles. Run mode presents the CPU read address and returns
// read data with the chips' output inversion removed.
//
// Handshake: a request is taken when prog_mode=1, wr_req=1 and the block is
// in IDLE (busy=0) at a rising edge; requests at any other time are dropped,
// never queued. Completion is the one-cycle wr_done pulse, and verify_err is
// valid from that pulse until the next accepted request.
//
// Every RAM-side output is a register, so ram_we_n only ever changes on a
// clock edge and cannot glitch from input activity.
module sap_ram_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              wr_done,
  output logic              verify_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  input  logic [DATA_W-1:0] ram_o,
  output logic [2:0]        fsm_state
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WRITE  = 3'd2,
    HOLD   = 3'd3,
    VERIFY = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] a_n;
  logic [DATA_W-1:0] d_n;
  logic              cs_n_n;
  logic              we_n_n;
  logic              busy_n;
  logic              done_n;
  logic              err_n;
  logic [DATA_W-1:0] rd_n;

  assign fsm_state = state;

  // Next state plus next value of every registered output. ram_d doubles as
  // the captured write data, since it is held constant for the whole sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = ram_a;
    d_n     = ram_d;
    cs_n_n  = ram_cs_n;
    we_n_n  = 1'b1;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = verify_err;
    rd_n    = rd_data;
    case (state)
      IDLE: begin
        if (prog_mode && wr_req) begin
          state_n = SETUP;
          a_n     = wr_addr;
          d_n     = wr_data;
          cs_n_n  = 1'b0;
          busy_n  = 1'b1;
          err_n   = 1'b0;
        end else if (!prog_mode) begin
          a_n    = rd_addr;
          cs_n_n = 1'b0;
        end else begin
          cs_n_n = 1'b1;
        end
        // Only sample the chip once it has been selected with a run address.
        if (!prog_mode && !ram_cs_n) begin
          rd_n = ~ram_o;
        end
      end
      SETUP: begin
        state_n = WRITE;
        cnt_n   = '0;
        we_n_n  = 1'b0;
      end
      WRITE: begin
        if (cnt == CNT_LAST) begin
          state_n = HOLD;
        end else begin
          cnt_n  = cnt + 1'b1;
          we_n_n = 1'b0;
        end
      end
      HOLD: begin
        state_n = VERIFY;
      end
      VERIFY: begin
        state_n = DONE;
        if (~ram_o != ram_d) begin
          err_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        // Leave DONE straight into whichever mode is now selected.
        if (!prog_mode) begin
          a_n    = rd_addr;
          cs_n_n = 1'b0;
        end else begin
          cs_n_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset also releases ram_we_n on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ram_a      <= '0;
      ram_d      <= '0;
      ram_cs_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      busy       <= 1'b0;
      wr_done    <= 1'b0;
      verify_err <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ram_a      <= a_n;
      ram_d      <= d_n;
      ram_cs_n   <= cs_n_n;
      ram_we_n   <= we_n_n;
      busy       <= busy_n;
      wr_done    <= done_n;
      verify_err <= err_n;
      rd_data    <= rd_n;
    end
  end

endmodule

// File: tb/tb_sap_ram_loader.sv
// Bench for sap_ram_loader: external SRAM model, randomized write/read traffic,
// a reference memory image and a scoreboard checked by a separate monitor.
module tb_sap_ram_loader;

  localparam int WE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_mode = 1'b0;
  logic       wr_req = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] rd_addr = '0;
  logic       busy, wr_done, verify_err;
  logic [7:0] rd_data;
  logic [3:0] ram_a;
  logic [7:0] ram_d;
  logic       ram_cs_n, ram_we_n;
  logic [7:0] ram_o;
  logic [2:0] fsm_state;

  sap_ram_loader #(.ADDR_W(4), .DATA_W(8), .WE_CYCLES(WE)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .wr_done(wr_done),
    .verify_err(verify_err), .rd_addr(rd_addr), .rd_data(rd_data),
    .ram_a(ram_a), .ram_d(ram_d), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
    .ram_o(ram_o), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- external SRAM model ----------------
  logic [7:0] mem [0:15];
  logic       fault_en = 1'b0;
  logic [3:0] fault_addr = 4'h3;
  logic [7:0] fault_val = 8'hA4;
  int         we_low_total = 0;
  logic       prev_we_low = 1'b0;
  logic [3:0] prev_a = '0;
  logic [7:0] prev_d = '0;

  assign ram_o = ram_cs_n ? 8'hFF :
                 ~((fault_en && ram_a == fault_addr) ? fault_val : mem[ram_a]);

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (ram_we_n === 1'b0) begin
        we_low_total++;
        chk("we_low_while_deselected", 32'(ram_cs_n), 32'd0);
        if (prev_we_low) begin
          chk("addr_stable_in_write", 32'(ram_a), 32'(prev_a));
          chk("data_stable_in_write", 32'(ram_d), 32'(prev_d));
        end
        if (ram_cs_n === 1'b0) mem[ram_a] = ram_d;
      end
      prev_we_low = (ram_we_n === 1'b0);
      prev_a = ram_a;
      prev_d = ram_d;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        err;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
  } rd_exp_t;

  wr_exp_t exp_q[$];
  rd_exp_t rd_q[$];
  int      done_seen = 0;
  int      last_we = 0;

  // Monitor: pairs each wr_done pulse and each due read with its expectation.
  initial begin
    wr_exp_t e;
    rd_exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_we = we_low_total;
      end else begin
        if (wr_done === 1'b1) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wr_done: got a pulse, required none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("wr_done_cycle", 32'(cyc), e.cyc);
            chk("verify_err", 32'(verify_err), 32'(e.err));
            chk("ram_content", 32'(mem[e.addr]), 32'(e.data));
            chk("we_pulse_cycles", 32'(we_low_total - last_we), 32'(WE));
            chk("busy_after_done", 32'(busy), 32'd0);
          end
          last_we = we_low_total;
        end
        while (rd_q.size() > 0 && rd_q[0].cyc <= 32'(cyc)) begin
          r = rd_q.pop_front();
          if (r.cyc != 32'(cyc)) begin
            total++;
            bad++;
            $display("FAIL rd_missed: due at cycle %0d, now %0d", r.cyc, cyc);
          end else begin
            chk("rd_data", 32'(rd_data), 32'(r.data));
          end
        end
      end
    end
  end

  // ---------------- reference model and drivers ----------------
  logic [7:0] ref_mem [0:15];
  logic       last_err = 1'b0;
  logic [7:0] last_rd = '0;

  function automatic logic model_err(input logic [3:0] a, input logic [7:0] d);
    return fault_en && (a == fault_addr) && (fault_val != d);
  endfunction

  // Issue a run-mode read now (at a negedge); data due two edges later.
  task automatic do_read(input logic [3:0] a);
    rd_exp_t r;
    rd_addr = a;
    r.cyc = 32'(cyc + 2);
    r.data = ref_mem[a];
    last_rd = ref_mem[a];
    rd_q.push_back(r);
    @(negedge clk);
  endtask

  // Issue one write now (at a negedge), optionally spamming wr_req while busy
  // and/or dropping prog_mode mid-write; returns at the negedge after wr_done.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit spam, input bit drop);
    wr_exp_t e;
    int d0;
    d0 = done_seen;
    prog_mode = 1'b1;
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
    e.cyc = 32'(cyc + 7);
    e.addr = a;
    e.data = d;
    e.err = model_err(a, d);
    last_err = e.err;
    exp_q.push_back(e);
    ref_mem[a] = d;
    @(negedge clk);
    wr_req = 1'b0;
    wr_addr = 4'($urandom_range(0, 15));
    wr_data = 8'($urandom_range(0, 255));
    chk("busy_set", 32'(busy), 32'd1);
    @(negedge clk);
    if (spam) begin
      wr_req = 1'b1;
      wr_addr = 4'h7;
      wr_data = 8'($urandom_range(0, 255));
    end
    if (drop) prog_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_seen != d0) break;
      @(negedge clk);
    end
    if (done_seen == d0) begin
      total++;
      bad++;
      $display("FAIL wr_done_timeout: no pulse for write to %0h", a);
    end
    if (drop) begin
      do_read(a);
      do_read(4'($urandom_range(0, 15)));
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_done"}, 32'(wr_done), 32'd0);
    chk({tag, "_verify_err"}, 32'(verify_err), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_ram_we_n"}, 32'(ram_we_n), 32'd1);
    chk({tag, "_ram_cs_n"}, 32'(ram_cs_n), 32'd1);
    chk({tag, "_ram_a"}, 32'(ram_a), 32'd0);
    chk({tag, "_ram_d"}, 32'(ram_d), 32'd0);
    chk({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // Reset held for two edges with a write request pending.
    rst_n = 1'b0;
    prog_mode = 1'b1;
    wr_req = 1'b1;
    wr_addr = 4'h9;
    wr_data = 8'h3C;
    repeat (2) begin
      @(posedge clk);
      #1;
      reset_checks("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);

    // Single write, then read-back fault, then a clean rewrite.
    do_write(4'h3, 8'hA5, 1'b0, 1'b0);
    fault_en = 1'b1;
    do_write(4'h3, 8'hA5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("verify_err_sticky", 32'(verify_err), 32'(last_err));
    fault_en = 1'b0;
    do_write(4'h3, 8'hA5, 1'b0, 1'b0);

    // Fill every address, back to back.
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 17), 1'b0, 1'b0);

    // Request spam while busy, then prog_mode dropped mid-write.
    do_write(4'h2, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    do_write(4'h5, 8'($urandom_range(0, 255)), 1'b0, 1'b1);

    // Write requests in run mode must be ignored.
    prog_mode = 1'b0;
    wr_req = 1'b1;
    wr_addr = 4'h7;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("run_mode_req_ignored", 32'(busy), 32'd0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);

    // Run-mode sweep and random reads.
    for (int i = 0; i < 16; i++) do_read(4'(i));
    repeat (12) do_read(4'($urandom_range(0, 15)));
    repeat (2) @(negedge clk);

    // Program mode: rd_addr movement must not disturb rd_data.
    prog_mode = 1'b1;
    repeat (4) begin
      rd_exp_t r;
      rd_addr = 4'($urandom_range(0, 15));
      r.cyc = 32'(cyc + 2);
      r.data = last_rd;
      rd_q.push_back(r);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Random write traffic with random gaps, spam and mode drops.
    repeat (25) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      do_write(a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset landing in the middle of the write pulse (same data rewritten).
    a = 4'($urandom_range(0, 15));
    prog_mode = 1'b1;
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = ref_mem[a];
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    chk("mid_write_we_low", 32'(ram_we_n), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset_we_n", 32'(ram_we_n), 32'd1);
    chk("mid_reset_state", 32'(fsm_state), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_cs_n", 32'(ram_cs_n), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    prog_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Final sweep of the whole image.
    for (int i = 0; i < 16; i++) do_read(4'(i));

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
    end
    chk("write_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run ever wedges.
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap_ram_loader.md
Name: sap_ram_loader

Overview:
- Sits directly upstream of the 16x4 SRAM pair (two f189 chips ganged for 8-bit words). It owns the RAM address, data, chip select and write enable pins.
- In program mode it turns single-word write requests (front-panel switches or bench) into glitch-free write cycles: setup, write pulse, hold, then read-back verify.
- In run mode it presents the CPU's memory address and returns read data with the chips' output inversion removed.

Parameters:
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 8, word width (two 4-bit chips side by side).
- WE_CYCLES, 2, clock cycles ram_we_n is held low per write (>=1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- prog_mode  in  1  1 = program mode, 0 = run mode.
- wr_req  in  1  write request, sampled only in program mode while busy=0.
- wr_addr  in  ADDR_W  write address, captured with wr_req.
- wr_data  in  DATA_W  write data (true polarity), captured with wr_req.
- busy  out  1  write sequence in progress.
- wr_done  out  1  one-cycle pulse when a write sequence completes.
- verify_err  out  1  sticky flag: read-back mismatch; cleared by reset or the next accepted wr_req.
- rd_addr  in  ADDR_W  run-mode read address, from the memory address register.
- rd_data  out  DATA_W  registered read data, true polarity.
- ram_a  out  ADDR_W  to the chip address inputs.
- ram_d  out  DATA_W  to the chip data inputs.
- ram_cs_n  out  1  chip select, active low.
- ram_we_n  out  1  write enable, active low.
- ram_o  in  DATA_W  chip outputs, inverted data.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, wr_done=0, verify_err=0, rd_data=0, ram_we_n=1, ram_cs_n=1, ram_a=0, ram_d=0.
  - A reset that lands mid-write forces ram_we_n=1 on that same edge.
- All RAM-side outputs are registered. No combinational path from any input to ram_we_n.
- FSM states: IDLE, SETUP, WRITE, HOLD, VERIFY, DONE.
- IDLE:
  - prog_mode=0: ram_cs_n=0, ram_we_n=1, ram_a=rd_addr (registered).
  - rd_data = ~ram_o, registered one cycle after ram_a updates. Read latency from rd_addr change to rd_data is 2 clk.
  - prog_mode=1 and wr_req=1: capture wr_addr and wr_data, busy=1, clear verify_err, go to SETUP.
  - prog_mode=1 and wr_req=0: ram_cs_n=1, ram_we_n=1; rd_data holds its value.
- SETUP (1 cycle): ram_a=captured address, ram_d=captured data, ram_cs_n=0, ram_we_n=1. Go to WRITE.
- WRITE (WE_CYCLES cycles, internal counter): ram_we_n=0; ram_a and ram_d stable. Go to HOLD.
- HOLD (1 cycle): ram_we_n=1; ram_a, ram_d and ram_cs_n unchanged. Go to VERIFY.
- VERIFY (1 cycle): chip is in read (cs_n=0, we_n=1).
  - On the exit edge compare ~ram_o with the captured data; a mismatch sets verify_err. Go to DONE.
- DONE (1 cycle): wr_done=1, busy=0 on the exit edge. Return to IDLE.
- Sequence length with WE_CYCLES=2: wr_req edge to wr_done pulse is 6 cycles. The next request can be accepted on the cycle after DONE.
- Address and data are never changed while ram_we_n=0. ram_we_n is never low while ram_cs_n=1.
- wr_req while busy=1: ignored, no queuing.
- wr_req while prog_mode=0: ignored.
- prog_mode falls mid-sequence: the sequence runs to DONE, then run mode resumes. No write is aborted.
- rd_addr changes in program mode have no effect.
- Address wrap: no auto-increment; every address 0..15 is written explicitly.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wr_req=1 -> all outputs at reset values, ram_we_n=1 throughout, busy=0.
- Single write: prog_mode=1, wr_req pulse with addr=4'h3, data=8'hA5 -> ram_we_n low for exactly 2 cycles; ram_a=3 and ram_d=A5 stable from SETUP to HOLD; wr_done pulses 6 cycles after request; verify_err=0.
- Read-back fault: RAM model forced to return ~8'hA4 at address 3 -> verify_err=1 after DONE. A following good write to address 3 clears it.
- Fill and run: write data=addr*17 to addresses 0..15, drop prog_mode, sweep rd_addr 0..15 -> rd_data=addr*17, each 2 cycles after rd_addr changes.
- Busy/ignore: second wr_req (addr=7) during WRITE -> ignored; only one write pulse occurs; address 7 unchanged.
- Mode drop and reset mid-write: drop prog_mode in WRITE -> sequence completes, wr_done pulses, then run reads. In a separate run, assert rst_n=0 in WRITE -> ram_we_n=1 and state=IDLE on that edge.
